alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one combinational ALU datapath (2-bit opcode, 8-bit a/b, 8-bit out) between two requesters.
- Arbitrates round-robin between them and registers the operands to drive the ALU.
- Captures the ALU result and returns it with the winning requester's ID over a valid/ready response channel.
- Sits between issuing logic and the ALU instance; the ALU itself stays outside this block.

Parameters:
- DW, 8, ALU operand/result width.
- OPW, 2, ALU opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_opcode  in  OPW  requester 0 opcode.
- req0_a  in  DW  requester 0 operand a.
- req0_b  in  DW  requester 0 operand b.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same as above, for requester 1.
- alu_opcode  out  OPW  opcode to ALU.
- alu_a  out  DW  operand a to ALU.
- alu_b  out  DW  operand b to ALU.
- alu_out  in  DW  ALU result (combinational from alu_* outputs).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that owns the result.
- rsp_data  out  DW  captured ALU result.
- op_count  out  8  completed-operation counter.

Behaviour:
- Reset: clk and rst_n as above; reset is synchronous and active-low, sampled only on the clk rising edge.
- Reset values: state=IDLE; all ready/valid outputs 0; alu_opcode, alu_a, alu_b, rsp_data, rsp_id 0; op_count 0; priority pointer = requester 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and asserted only for the granted requester.
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester named by the priority pointer is granted.
  - On the grant edge: latch opcode/a/b into the alu_* registers and latch the ID; go to EXEC; the pointer moves to the non-granted requester.
  - If neither valid is high, stay in IDLE; the pointer is unchanged.
- EXEC (one cycle):
  - alu_* hold the latched operands.
  - At the end of the cycle, capture alu_out into rsp_data and go to RESP.
  - No req*_ready is asserted.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are stable until the handshake.
  - When rsp_valid and rsp_ready are both high on an edge: op_count increments (8-bit, wraps 255->0); go to IDLE.
  - rsp_ready may already be high on RESP entry; the handshake then completes after one RESP cycle.
- Latency: grant edge to rsp_valid high is 2 cycles. Minimum issue interval is 3 cycles per operation.
- alu_* outputs keep their last value outside EXEC; no glitching to 0.
- Requesters must hold their fields stable while valid=1 and ready=0. A requester that drops valid before ready is simply not granted.
- Simultaneous request while in RESP: it is not accepted until the FSM returns to IDLE. There is no bypass from RESP straight to grant.
- Reset mid-operation: the in-flight op is discarded, rsp_valid drops next edge, op_count clears.
- Arithmetic is done by the ALU only; this block does no computation except op_count.

Decomposition:
- Shared package holds:
  - ALU opcode width constant (OPW=2) and data width (DW=8).
  - FSM state enum {IDLE, EXEC, RESP}.
  - Requester ID constants REQ0=0, REQ1=1.
- Natural sub-module: rr_arbiter2, the 2-input round-robin grant with its pointer register and an update-enable input.
- FSM and datapath registers stay in the top.

Test Plan:
The bench stubs alu_out = alu_a + alu_b (mod 256), which checks routing independent of the ALU's opcode semantics.
1. Single request: req0 opcode=2'b11, a=8'h80, b=8'h01, rsp_ready=1 -> req0_ready pulses once; alu_opcode=11; 2 cycles later rsp_valid=1, rsp_data=8'h81, rsp_id=0; op_count=1.
2. Round-robin: both valid after reset. Req0 a=8'h01,b=8'h00; req1 a=8'hAA,b=8'h55 -> first rsp_id=0, data=8'h01; second rsp_id=1, data=8'hFF; then a third simultaneous pair grants req0.
3. Back-pressure: rsp_ready=0 for 5 cycles with req1 a=8'h1F,b=8'h11 pending -> rsp_valid stays high, rsp_data=8'h30 stable, no req*_ready; on rsp_ready=1 one handshake, op_count+1.
4. Request during RESP: req1 asserts while in RESP -> req1_ready only in the IDLE cycle after the response handshake.
5. Reset mid-op: rst_n=0 for 1 cycle during EXEC -> next cycle state IDLE, rsp_valid=0, op_count=0, alu_* =0; a later request completes normally.
6. Counter wrap: 256 consecutive completed ops -> op_count returns to 0; no lost or duplicated responses, and the IDs alternate when both requesters stay valid.

Source files
------------

// File: rtl/alu_req_arbiter_pkg.sv
// alu_req_arbiter_pkg: shared widths, FSM states and requester IDs
package alu_req_arbiter_pkg;
  localparam int DW = 8;
  localparam int OPW = 2;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: requester, ALU and response signals of the arbiter
interface alu_req_arbiter_if;
  import alu_req_arbiter_pkg::*;
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_opcode;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_opcode;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic [OPW-1:0] alu_opcode;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_out;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [DW-1:0]  rsp_data;
  logic [7:0]     op_count;
  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready, alu_opcode, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, op_count
  );
  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready, alu_opcode, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, op_count
  );
endinterface

// File: rtl/alu_req_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant; pointer advances only on an enabled grant
module rr_arbiter2
  import alu_req_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       id_o
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt_o = (&req_i) ? (ptr_q == REQ1 ? 2'b10 : 2'b01) : req_i;
    id_o  = gnt_o[1];
    ptr_d = (en_i && |req_i) ? ~id_o : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= REQ0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one external ALU between two requesters via IDLE/EXEC/RESP FSM
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
(
  input logic clk,
  input logic rst_n,
  alu_req_arbiter_if.slave bus
);
  state_e         state_q, state_d;
  logic [1:0]     gnt;
  logic           gnt_id, idle, grant, hs;
  logic [OPW-1:0] opc_q, opc_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d, data_q, data_d;
  logic           id_q, id_d;
  logic [7:0]     cnt_q, cnt_d;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({bus.req1_valid, bus.req0_valid}),
    .en_i  (idle),
    .gnt_o (gnt),
    .id_o  (gnt_id)
  );
  always_comb begin
    idle    = state_q == IDLE;
    grant   = idle && |gnt;
    hs      = state_q == RESP && bus.rsp_ready;
    state_d = idle ? (grant ? EXEC : IDLE) :
              state_q == EXEC ? RESP :
              (state_q == RESP && !hs) ? RESP : IDLE;
    opc_d   = grant ? (gnt_id ? bus.req1_opcode : bus.req0_opcode) : opc_q;
    a_d     = grant ? (gnt_id ? bus.req1_a : bus.req0_a) : a_q;
    b_d     = grant ? (gnt_id ? bus.req1_b : bus.req0_b) : b_q;
    id_d    = grant ? gnt_id : id_q;
    data_d  = state_q == EXEC ? bus.alu_out : data_q;
    cnt_d   = hs ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= REQ0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.req0_ready = idle & gnt[0];
  assign bus.req1_ready = idle & gnt[1];
  assign bus.alu_opcode = opc_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_valid  = state_q == RESP;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = data_q;
  assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: random and directed scoreboard bench with an add-stub ALU
module tb_alu_req_arbiter;
  import alu_req_arbiter_pkg::*;
  typedef struct packed {logic id; logic [7:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_req_arbiter_if bus();
  assign bus.alu_out = bus.alu_a + bus.alu_b;
  alu_req_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] exp_cnt = 8'd0;
  int prio = 0;
  logic pend[2];
  logic [1:0] op_m[2];
  logic [7:0] a_m[2], b_m[2];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.req0_valid = pend[0]; bus.req0_opcode = op_m[0]; bus.req0_a = a_m[0]; bus.req0_b = b_m[0];
    bus.req1_valid = pend[1]; bus.req1_opcode = op_m[1]; bus.req1_a = a_m[1]; bus.req1_b = b_m[1];
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    pend[r] = 1'b1; op_m[r] = op; a_m[r] = a; b_m[r] = b;
    drive();
  endtask

  task automatic rand_req(input int r);
    set_req(r, 2'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic clear_reqs();
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
    exp_cnt = 8'd0;
    prio = 0;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_op_count", bus.op_count, 0);
    chk("rst_alu", {bus.alu_opcode, bus.alu_a, bus.alu_b}, 0);
    chk("rst_rsp", {bus.rsp_id, bus.rsp_data}, 0);
    chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
  endtask

  // One full transaction from IDLE: grant, EXEC, stall for `stall` RESP cycles, handshake.
  task automatic run_op(input int stall, input bit rnd, input bit raise1);
    int w;
    exp_t cur;
    @(negedge clk);
    w = (pend[0] && pend[1]) ? prio : (pend[1] ? 1 : 0);
    chk("grant_req0_ready", bus.req0_ready, w == 0);
    chk("grant_req1_ready", bus.req1_ready, w == 1);
    chk("idle_rsp_valid", bus.rsp_valid, 0);
    cur.id = w[0];
    cur.data = a_m[w] + b_m[w];
    sb.push_back(cur);
    prio = 1 - w;
    bus.rsp_ready = (stall == 0);
    tick();
    pend[w] = 1'b0;
    drive();
    @(negedge clk);
    chk("exec_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("exec_rsp_valid", bus.rsp_valid, 0);
    chk("exec_alu_opcode", bus.alu_opcode, op_m[w]);
    chk("exec_alu_a", bus.alu_a, a_m[w]);
    chk("exec_alu_b", bus.alu_b, b_m[w]);
    tick();
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", bus.rsp_valid, 1);
      chk("stall_rsp", {bus.rsp_id, bus.rsp_data}, cur);
      chk("stall_ready", {bus.req1_ready, bus.req0_ready}, 0);
      if (raise1 && i == 0 && !pend[1]) rand_req(1);
      if (rnd && !pend[0] && $urandom_range(0, 2) == 0) rand_req(0);
      if (rnd && !pend[1] && $urandom_range(0, 2) == 0) rand_req(1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("resp_rsp_valid", bus.rsp_valid, 1);
    chk("resp_ready", {bus.req1_ready, bus.req0_ready}, 0);
    tick();
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("op_count", bus.op_count, exp_cnt);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d data=%0h want no response", bus.rsp_id, bus.rsp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", bus.rsp_id, mon_e.id);
        chk("rsp_data", bus.rsp_data, mon_e.data);
        exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  initial begin
    op_m[0] = 2'd0; op_m[1] = 2'd0; a_m[0] = 8'd0; a_m[1] = 8'd0; b_m[0] = 8'd0; b_m[1] = 8'd0;
    do_reset();
    set_req(0, 2'b11, 8'h80, 8'h01);
    run_op(0, 0, 0);
    do_reset();
    set_req(0, 2'b00, 8'h01, 8'h00);
    set_req(1, 2'b01, 8'hAA, 8'h55);
    run_op(0, 0, 0);
    run_op(1, 0, 0);
    set_req(0, 2'b10, 8'h10, 8'h20);
    set_req(1, 2'b11, 8'h33, 8'h44);
    run_op(0, 0, 0);
    run_op(0, 0, 0);
    set_req(1, 2'b00, 8'h1F, 8'h11);
    run_op(5, 0, 0);
    set_req(0, 2'b01, 8'h05, 8'h06);
    run_op(2, 0, 1);
    run_op(0, 0, 0);
    set_req(0, 2'b10, 8'h12, 8'h34);
    tick();
    rst_n = 1'b0;
    clear_reqs();
    tick();
    rst_n = 1'b1;
    sb.delete();
    exp_cnt = 8'd0;
    prio = 0;
    chk("midop_rsp_valid", bus.rsp_valid, 0);
    chk("midop_op_count", bus.op_count, 0);
    chk("midop_alu", {bus.alu_opcode, bus.alu_a, bus.alu_b}, 0);
    set_req(1, 2'b01, 8'h0F, 8'h01);
    run_op(1, 0, 0);
    set_req(0, 2'b11, 8'h21, 8'h43);
    bus.rsp_ready = 1'b0;
    tick();
    pend[0] = 1'b0;
    drive();
    tick();
    @(negedge clk);
    chk("resp_before_rst", bus.rsp_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    exp_cnt = 8'd0;
    prio = 0;
    chk("resp_rst_rsp_valid", bus.rsp_valid, 0);
    chk("resp_rst_op_count", bus.op_count, 0);
    for (int k = 0; k < 60; k++) begin
      if (!pend[0] && $urandom_range(0, 1) == 1) rand_req(0);
      if (!pend[1] && ($urandom_range(0, 1) == 1 || !pend[0])) rand_req(1);
      run_op(int'($urandom_range(0, 3)), 1, 0);
    end
    do_reset();
    for (int k = 0; k < 256; k++) begin
      if (!pend[0]) rand_req(0);
      if (!pend[1]) rand_req(1);
      run_op(int'($urandom_range(0, 1)), 0, 0);
    end
    chk("wrap_op_count", bus.op_count, 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
